// File: rtl/elastic_async_operator.sv
// Req/ack arithmetic node: operand slots feed a result FIFO read by independent consumer pointers.
// Define ELASTIC_ASYNC_OPERATOR_STATS_EN to add the stat_fired/stat_stall counters.
module elastic_async_operator #(
  parameter int unsigned           data_width  = 32,
  parameter string                 op          = "reg",
  parameter logic [data_width-1:0] immediate   = '0,
  parameter int unsigned           input_size  = 1,
  parameter int unsigned           output_size = 1,
  parameter int unsigned           depth       = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic [input_size-1:0]             req_l,
  input  logic [input_size-1:0]             ack_l,
  input  logic [data_width*input_size-1:0]  din,
  input  logic [output_size-1:0]            req_r,
  output logic [output_size-1:0]            ack_r,
  output logic [data_width*output_size-1:0] dout
`ifdef ELASTIC_ASYNC_OPERATOR_STATS_EN
  ,
  output logic [31:0]                       stat_fired,
  output logic [31:0]                       stat_stall
`endif
);

  localparam int unsigned addr_w = $clog2(depth);

  typedef logic [addr_w:0] ptr_t;
  typedef enum logic [2:0] {OpId, OpAdd, OpSub, OpMul, OpAddi, OpSubi, OpMuli} op_e;

  localparam op_e op_sel = (op == "add")  ? OpAdd  :
                           (op == "sub")  ? OpSub  :
                           (op == "mul")  ? OpMul  :
                           (op == "addi") ? OpAddi :
                           (op == "subi") ? OpSubi :
                           (op == "muli") ? OpMuli : OpId;

  logic                   run_q;
  logic [input_size-1:0]  has_q;
  logic [data_width-1:0]  slot_q [input_size];
  logic [data_width-1:0]  mem_q  [depth];
  logic [output_size-1:0] mask_q [depth];
  ptr_t                   wr_q;
  ptr_t                   head_q;
  ptr_t                   rd_q   [output_size];

  logic                   full;
  logic                   empty;
  logic                   fire;
  logic                   retire;
  logic [output_size-1:0] grant;
  logic [data_width-1:0]  result;

  // head_q trails the slowest consumer; only it decides fullness
  always_comb begin
    full   = (wr_q - head_q) == ptr_t'(depth);
    empty  = wr_q == head_q;
    fire   = (&has_q) && !full;
    retire = !empty && (mask_q[head_q[addr_w-1:0]] == '0);
    grant  = '0;
    for (int j = 0; j < int'(output_size); j++) begin
      grant[j] = req_r[j] && (rd_q[j] != wr_q) && !ack_r[j];
    end
  end

  always_comb begin
    result = slot_q[0];
    case (op_sel)
      OpAdd:  for (int i = 1; i < int'(input_size); i++) result = result + slot_q[i];
      OpSub:  for (int i = 1; i < int'(input_size); i++) result = result - slot_q[i];
      OpMul:  for (int i = 1; i < int'(input_size); i++) result = result * slot_q[i];
      OpAddi: result = slot_q[0] + immediate;
      OpSubi: result = slot_q[0] - immediate;
      OpMuli: result = slot_q[0] * immediate;
      default: result = slot_q[0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= 1'b0;
      has_q  <= '0;
      req_l  <= '0;
      ack_r  <= '0;
      dout   <= '0;
      wr_q   <= '0;
      head_q <= '0;
      for (int j = 0; j < int'(output_size); j++) rd_q[j] <= '0;
      for (int e = 0; e < int'(depth); e++) mask_q[e] <= '0;
    end else begin
      // run_q delays the first request by one cycle after reset release
      run_q <= 1'b1;
      for (int i = 0; i < int'(input_size); i++) begin
        if (fire) begin
          has_q[i] <= 1'b0;
          req_l[i] <= 1'b0;
        end else if (ack_l[i] && !has_q[i]) begin
          slot_q[i] <= din[i*data_width +: data_width];
          has_q[i]  <= 1'b1;
          req_l[i]  <= 1'b0;
        end else begin
          req_l[i] <= run_q && !has_q[i];
        end
      end

      if (fire) begin
        mem_q[wr_q[addr_w-1:0]]  <= result;
        mask_q[wr_q[addr_w-1:0]] <= '1;
        wr_q                     <= wr_q + ptr_t'(1);
      end
      if (retire) head_q <= head_q + ptr_t'(1);

      // a read entry can never alias the push slot: that would require a full FIFO
      for (int j = 0; j < int'(output_size); j++) begin
        if (grant[j]) begin
          ack_r[j]                             <= 1'b1;
          dout[j*data_width +: data_width]     <= mem_q[rd_q[j][addr_w-1:0]];
          rd_q[j]                              <= rd_q[j] + ptr_t'(1);
          mask_q[rd_q[j][addr_w-1:0]][j]       <= 1'b0;
        end else begin
          ack_r[j] <= 1'b0;
        end
      end
    end
  end

`ifdef ELASTIC_ASYNC_OPERATOR_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fired <= '0;
      stat_stall <= '0;
    end else begin
      if (fire) stat_fired <= stat_fired + 32'd1;
      if ((&has_q) && full) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
